// File: rtl/sis_stream.sv
// Streaming input-selection stage: gathers one residual row over LANES-wide beats and
// emits the DCT2 butterfly / DCT8 reversal / DST7 passthrough vector under valid/ready.
module sis_stream #(
  parameter int WIDTH = 16,
  parameter int MAX_N = 32,
  parameter int LANES = 8,
  localparam int OW   = WIDTH + $clog2(MAX_N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data [LANES-1:0],
  input  logic [1:0]              transform_type,
  input  logic [1:0]              size_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OW-1:0]    out_vector [MAX_N-1:0],
  output logic [1:0]              out_size
);

  localparam int IW   = $clog2(MAX_N);
  localparam int MAXB = MAX_N / LANES;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [1:0] MAXCODE = 2'($clog2(MAX_N) - 2);

  typedef enum logic [1:0] {FILL, CALC, HOLD} state_t;

  function automatic logic [1:0] clamp_size(input logic [1:0] s);
    return (s > MAXCODE) ? MAXCODE : s;
  endfunction

  function automatic int n_of(input logic [1:0] s);
    return 4 << s;
  endfunction

  function automatic int nb_of(input logic [1:0] s);
    return (n_of(s) <= LANES) ? 1 : n_of(s) / LANES;
  endfunction

  function automatic logic signed [OW-1:0] sext(input logic signed [WIDTH-1:0] x);
    return {{(OW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  state_t                  state, state_nxt;
  logic [CW-1:0]           beat;
  logic [1:0]              size_cur;
  logic                    last_beat;
  logic                    accept;
  logic signed [WIDTH-1:0] row_p0 [MAX_N-1:0];
  logic [1:0]              type_p0;
  logic [1:0]              size_p0;
  logic signed [OW-1:0]    vec_p1 [MAX_N-1:0];
  int                      n_p0;
  logic [IW-1:0]           ridx;
  logic [IW-1:0]           hidx;

  // On beat 0 the size has not been latched yet, so the live selector decides NB.
  assign size_cur  = (beat == '0) ? clamp_size(size_sel) : size_p0;
  assign last_beat = (int'(beat) == nb_of(size_cur) - 1);
  assign accept    = in_valid && (state == FILL);
  assign n_p0      = n_of(size_p0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_nxt = CALC;
      end
      CALC: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Stage p0: row collection; type and size latched on the first beat only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat    <= '0;
      type_p0 <= '0;
      size_p0 <= '0;
      row_p0  <= '{default: '0};
    end else if (accept) begin
      for (int k = 0; k < LANES; k++)
        row_p0[IW'(int'(beat) * LANES + k)] <= in_data[k];
      if (beat == '0) begin
        type_p0 <= transform_type;
        size_p0 <= clamp_size(size_sel);
      end
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  always_comb begin
    vec_p1 = '{default: '0};
    ridx   = '0;
    hidx   = '0;
    for (int i = 0; i < MAX_N; i++) begin
      ridx = IW'(n_p0 - 1 - i);
      hidx = IW'(n_p0 / 2 + i);
      if (i < n_p0) begin
        case (type_p0)
          2'b00: if (i < n_p0 / 2) begin
            vec_p1[i]    = sext(row_p0[i]) + sext(row_p0[ridx]);
            vec_p1[hidx] = sext(row_p0[i]) - sext(row_p0[ridx]);
          end
          2'b10:   vec_p1[i] = sext(row_p0[ridx]);
          default: vec_p1[i] = sext(row_p0[i]);
        endcase
      end
    end
  end

  // Stage p1: result captured in CALC and held stable through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vector <= '{default: '0};
      out_size   <= '0;
    end else if (state == CALC) begin
      out_vector <= vec_p1;
      out_size   <= size_p0;
    end
  end

endmodule

// File: tb/tb_sis_stream.sv
// Scoreboard bench for sis_stream: expected vectors are queued as rows are driven
// and popped when the block presents a vector.
module tb_sis_stream;
  localparam int WIDTH = 16;
  localparam int MAX_N = 32;
  localparam int LANES = 8;
  localparam int OW    = 21;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [WIDTH-1:0] in_data [LANES-1:0];
  logic [1:0] transform_type, size_sel, out_size;
  logic signed [OW-1:0] out_vector [MAX_N-1:0];

  always #5 clk = ~clk;

  sis_stream #(.WIDTH(WIDTH), .MAX_N(MAX_N), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .transform_type(transform_type), .size_sel(size_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
    .out_size(out_size)
  );

  typedef struct packed {
    logic [1:0]            size;
    logic [MAX_N*OW-1:0]   v;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   row_v [MAX_N];

  function automatic logic [MAX_N*OW-1:0] flat();
    logic [MAX_N*OW-1:0] f;
    for (int i = 0; i < MAX_N; i++) f[i*OW +: OW] = out_vector[i];
    return f;
  endfunction

  function automatic exp_t model(input int n, input logic [1:0] t, input logic [1:0] code);
    exp_t e;
    int   val;
    int   h;
    e.size = code;
    e.v    = '0;
    h      = n / 2;
    for (int i = 0; i < MAX_N; i++) begin
      val = 0;
      if (i < n) begin
        if (t == 2'b00)
          val = (i < h) ? row_v[i] + row_v[n-1-i] : row_v[i-h] - row_v[n-1-(i-h)];
        else if (t == 2'b10)
          val = row_v[n-1-i];
        else
          val = row_v[i];
      end
      e.v[i*OW +: OW] = OW'(val);
    end
    return e;
  endfunction

  // Drives up to max_beats beats of row_v; type/size are corrupted after beat 0.
  task automatic send_row(input logic [1:0] code, input logic [1:0] t, input int max_beats);
    int n;
    int nb;
    n  = 4 << code;
    nb = (n <= LANES) ? 1 : n / LANES;
    if (max_beats >= nb) exp_q.push_back(model(n, t, code));
    for (int b = 0; b < nb && b < max_beats; b++) begin
      @(negedge clk);
      in_valid       = 1'b1;
      transform_type = (b == 0) ? t : ~t;
      size_sel       = (b == 0) ? code : ~code;
      for (int k = 0; k < LANES; k++) in_data[k] = WIDTH'(row_v[b*LANES+k]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit seen);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    seen = out_valid;
  endtask

  task automatic rand_row();
    for (int i = 0; i < MAX_N; i++) row_v[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (flat() !== '0) begin bad++; $display("FAIL reset out_vector: got %h want 0", flat()); end
    total++; if (out_size !== 2'd0) begin bad++; $display("FAIL reset out_size: got %0d want 0", out_size); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dct2_32();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < MAX_N; i++) row_v[i] = i;
    send_row(2'd3, 2'b00, 4);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dct2_32 early valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL dct2_32 calc in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dct2_32 latency: got out_valid=%b want 1", out_valid); end
    e = exp_q.pop_front();
    total++; if (flat() !== e.v) begin bad++; $display("FAIL dct2_32 vector: got %h want %h", flat(), e.v); end
    total++; if (out_vector[0] !== 21'sd31) begin bad++; $display("FAIL dct2_32 out0: got %0d want 31", out_vector[0]); end
    total++; if (out_vector[16] !== -21'sd31) begin bad++; $display("FAIL dct2_32 out16: got %0d want -31", out_vector[16]); end
    total++; if (out_vector[31] !== -21'sd1) begin bad++; $display("FAIL dct2_32 out31: got %0d want -1", out_vector[31]); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dct2_32 pulse: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_dct8_8();
    exp_t e;
    bit   seen;
    for (int i = 0; i < MAX_N; i++) row_v[i] = (i < 8) ? i + 1 : 99;
    send_row(2'd1, 2'b10, 1);
    wait_valid(seen);
    total++; if (!seen) begin bad++; $display("FAIL dct8_8 timeout: got no out_valid want 1"); end
    else begin
      e = exp_q.pop_front();
      total++; if (flat() !== e.v) begin bad++; $display("FAIL dct8_8 vector: got %h want %h", flat(), e.v); end
      total++; if (out_vector[0] !== 21'sd8) begin bad++; $display("FAIL dct8_8 out0: got %0d want 8", out_vector[0]); end
      total++; if (out_size !== 2'd1) begin bad++; $display("FAIL dct8_8 out_size: got %0d want 1", out_size); end
    end
    @(negedge clk);
  endtask

  task automatic test_dst7_16();
    exp_t e;
    bit   seen;
    logic [1:0] types [2];
    types[0] = 2'b01;
    types[1] = 2'b11;
    for (int i = 0; i < MAX_N; i++) row_v[i] = -i;
    for (int r = 0; r < 2; r++) begin
      send_row(2'd2, types[r], 2);
      wait_valid(seen);
      total++; if (!seen) begin bad++; $display("FAIL dst7_16 timeout type=%0d: got no out_valid want 1", types[r]); end
      else begin
        e = exp_q.pop_front();
        total++; if (flat() !== e.v) begin bad++; $display("FAIL dst7_16 vector type=%0d: got %h want %h", types[r], flat(), e.v); end
        total++; if (out_vector[15] !== 21'h1FFFF1) begin bad++; $display("FAIL dst7_16 out15: got %h want 1ffff1", out_vector[15]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dct2_4_extremes();
    exp_t e;
    bit   seen;
    for (int i = 0; i < MAX_N; i++) row_v[i] = 1000 + i;
    row_v[0] = 32767; row_v[1] = -32768; row_v[2] = -32768; row_v[3] = 32767;
    row_v[5] = -5;
    send_row(2'd0, 2'b00, 1);
    wait_valid(seen);
    total++; if (!seen) begin bad++; $display("FAIL dct2_4 timeout: got no out_valid want 1"); end
    else begin
      e = exp_q.pop_front();
      total++; if (flat() !== e.v) begin bad++; $display("FAIL dct2_4 vector: got %h want %h", flat(), e.v); end
      total++; if (out_vector[0] !== 21'sd65534) begin bad++; $display("FAIL dct2_4 out0: got %0d want 65534", out_vector[0]); end
      total++; if (out_vector[1] !== -21'sd65536) begin bad++; $display("FAIL dct2_4 out1: got %0d want -65536", out_vector[1]); end
      total++; if (out_vector[4] !== 21'sd0) begin bad++; $display("FAIL dct2_4 out4: got %0d want 0", out_vector[4]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   seen;
    out_ready = 1'b0;
    rand_row();
    send_row(2'd3, 2'b10, 4);
    wait_valid(seen);
    total++; if (!seen) begin bad++; $display("FAIL bp timeout: got no out_valid want 1"); end
    else begin
      e = exp_q.pop_front();
      total++; if (flat() !== e.v) begin bad++; $display("FAIL bp vector: got %h want %h", flat(), e.v); end
      for (int c = 0; c < 5; c++) begin
        in_valid       = 1'b1;
        transform_type = 2'b00;
        size_sel       = 2'd0;
        for (int k = 0; k < LANES; k++) in_data[k] = WIDTH'($urandom);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp in_ready c=%0d: got %b want 0", c, in_ready); end
        total++; if (out_valid !== 1'b1 || flat() !== e.v) begin
          bad++; $display("FAIL bp hold c=%0d: got valid=%b %h want valid=1 %h", c, out_valid, flat(), e.v);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp release: got out_valid=%b want 0", out_valid); end
    end
    rand_row();
    send_row(2'd2, 2'b00, 2);
    wait_valid(seen);
    total++; if (!seen) begin bad++; $display("FAIL bp next timeout: got no out_valid want 1"); end
    else begin
      e = exp_q.pop_front();
      total++; if (flat() !== e.v) begin bad++; $display("FAIL bp next vector: got %h want %h", flat(), e.v); end
      total++; if (out_size !== e.size) begin bad++; $display("FAIL bp next out_size: got %0d want %0d", out_size, e.size); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    out_ready = 1'b1;
    rand_row();
    send_row(2'd3, 2'b00, 2);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
    total++; if (flat() !== '0) begin bad++; $display("FAIL rstmid out_vector: got %h want 0", flat()); end
    total++; if (out_size !== 2'd0) begin bad++; $display("FAIL rstmid out_size: got %0d want 0", out_size); end
    @(negedge clk);
    rst_n = 1'b1;
    rand_row();
    send_row(2'd3, 2'b10, 4);
    wait_valid(seen);
    total++; if (!seen) begin bad++; $display("FAIL rstmid timeout: got no out_valid want 1"); end
    else begin
      e = exp_q.pop_front();
      total++; if (flat() !== e.v) begin bad++; $display("FAIL rstmid vector: got %h want %h", flat(), e.v); end
      total++; if (out_size !== 2'd3) begin bad++; $display("FAIL rstmid out_size: got %0d want 3", out_size); end
    end
    @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    transform_type = 2'b00;
    size_sel       = 2'd0;
    for (int k = 0; k < LANES; k++) in_data[k] = '0;
    test_reset();
    test_dct2_32();
    test_dct8_8();
    test_dst7_16();
    test_dct2_4_extremes();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
